// File: rtl/ddr_rd_sched_if.sv
// ---------------------------------------------------------------------------
// ddr_rd_sched_if
// Handshake bundle between the DDR read scheduler and its two readers.
//   data_req_i / data_done_i     : data reader level request / completion pulse
//   param_req_i / param_done_i   : param reader level request / completion pulse
//   timeout_cyc_i                : watchdog limit in cycles (0 = disabled)
//   timeout_clr_i                : clears the sticky timeout flag
//   rd_ddr_en_o                  : grant to the data reader
//   rd_ddr_param_en_o            : grant to the parameter reader
//   busy_o                       : scheduler is not idle
//   timeout_o                    : sticky watchdog-release flag
// The slave modport is the scheduler; the master modport is the reader side.
// ---------------------------------------------------------------------------
interface ddr_rd_sched_if #(
  parameter int TO_W = 16
);
  logic            data_req_i;
  logic            data_done_i;
  logic            param_req_i;
  logic            param_done_i;
  logic [TO_W-1:0] timeout_cyc_i;
  logic            timeout_clr_i;
  logic            rd_ddr_en_o;
  logic            rd_ddr_param_en_o;
  logic            busy_o;
  logic            timeout_o;

  modport slave (
    input  data_req_i, data_done_i, param_req_i, param_done_i,
    input  timeout_cyc_i, timeout_clr_i,
    output rd_ddr_en_o, rd_ddr_param_en_o, busy_o, timeout_o
  );

  modport master (
    output data_req_i, data_done_i, param_req_i, param_done_i,
    output timeout_cyc_i, timeout_clr_i,
    input  rd_ddr_en_o, rd_ddr_param_en_o, busy_o, timeout_o
  );
endinterface

// File: rtl/ddr_rd_sched.sv
// ---------------------------------------------------------------------------
// ddr_rd_sched
// Arbitrates the single shared DDR read port between the feature-map data
// reader and the parameter reader. At most one enable is ever high; a grant
// is held until its owner pulses done or the watchdog expires, and every
// grant is followed by GAP_CYC dead cycles. Contested requests alternate
// round-robin, starting with the parameter reader after reset.
// Ports:
//   clk_i   : clock, rising edge
//   rstn_i  : asynchronous active-low reset
//   bus     : ddr_rd_sched_if slave modport (requests, dones, watchdog
//             control in; registered enables, busy and timeout flag out)
// ---------------------------------------------------------------------------
module ddr_rd_sched #(
  parameter int GAP_CYC = 2,
  parameter int TO_W    = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  ddr_rd_sched_if.slave   bus
);

  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_DATA  = 2'd1,
    GNT_PARAM = 2'd2,
    GAP       = 2'd3
  } state_t;

  typedef enum logic {
    LAST_DATA  = 1'b0,
    LAST_PARAM = 1'b1
  } last_t;

  state_t           state;
  last_t            last;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             rd_en;
  logic             param_en;
  logic             busy;
  logic             timeout;
  logic             expire;

  // The counter holds at all-ones so a very long grant with the watchdog
  // disabled can never wrap around and fake an expiry later.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (&v) ? v : v + TO_W'(1);
  endfunction

  assign expire = (bus.timeout_cyc_i != '0) &&
                  (to_cnt == bus.timeout_cyc_i - TO_W'(1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      last     <= LAST_DATA;
      to_cnt   <= '0;
      gap_cnt  <= '0;
      rd_en    <= 1'b0;
      param_en <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      // Clear first so a watchdog set later in this block wins the cycle.
      if (bus.timeout_clr_i) timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.data_req_i && (!bus.param_req_i || last == LAST_PARAM)) begin
            state  <= GNT_DATA;
            rd_en  <= 1'b1;
            busy   <= 1'b1;
            last   <= LAST_DATA;
            to_cnt <= '0;
          end else if (bus.param_req_i) begin
            state    <= GNT_PARAM;
            param_en <= 1'b1;
            busy     <= 1'b1;
            last     <= LAST_PARAM;
            to_cnt   <= '0;
          end
        end

        GNT_DATA: begin
          // A done pulse takes priority over a simultaneous expiry.
          if (bus.data_done_i || expire) begin
            state   <= GAP;
            rd_en   <= 1'b0;
            gap_cnt <= '0;
            if (!bus.data_done_i) timeout <= 1'b1;
          end else begin
            to_cnt <= sat_inc(to_cnt);
          end
        end

        GNT_PARAM: begin
          if (bus.param_done_i || expire) begin
            state    <= GAP;
            param_en <= 1'b0;
            gap_cnt  <= '0;
            if (!bus.param_done_i) timeout <= 1'b1;
          end else begin
            to_cnt <= sat_inc(to_cnt);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          rd_en    <= 1'b0;
          param_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_ddr_en_o       = rd_en;
  assign bus.rd_ddr_param_en_o = param_en;
  assign bus.busy_o            = busy;
  assign bus.timeout_o         = timeout;

endmodule

// File: tb/tb_ddr_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_sched
// Directed bench for ddr_rd_sched with GAP_CYC = 2, TO_W = 16. Inputs are
// driven 1 ns after the rising edge and outputs are read at the same point,
// so each tick() lands in the next cycle with that cycle's registered state.
// ---------------------------------------------------------------------------
module tb_ddr_rd_sched;

  logic clk;
  logic rstn;

  ddr_rd_sched_if #(.TO_W(16)) bus ();

  ddr_rd_sched #(.GAP_CYC(2), .TO_W(16)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  // Both enables high at once would corrupt the downstream DDR mux.
  always @(negedge clk) begin
    check("mutex", 32'(bus.rd_ddr_en_o & bus.rd_ddr_param_en_o), 32'd0);
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int  n;
    bit  exp_data;
    bit  held;

    bus.data_req_i    = 1'b0;
    bus.data_done_i   = 1'b0;
    bus.param_req_i   = 1'b0;
    bus.param_done_i  = 1'b0;
    bus.timeout_cyc_i = '0;
    bus.timeout_clr_i = 1'b0;
    rstn              = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_en",      32'(bus.rd_ddr_en_o),       32'd0);
    check("rst_pen",     32'(bus.rd_ddr_param_en_o), 32'd0);
    check("rst_busy",    32'(bus.busy_o),            32'd0);
    check("rst_timeout", 32'(bus.timeout_o),         32'd0);
    rstn = 1'b1;
    tick();

    // Single param request: 1-cycle latency, done after 20 cycles
    bus.param_req_i = 1'b1;
    tick();
    check("p_lat_pen",  32'(bus.rd_ddr_param_en_o), 32'd1);
    check("p_lat_en",   32'(bus.rd_ddr_en_o),       32'd0);
    check("p_lat_busy", 32'(bus.busy_o),            32'd1);
    bus.param_req_i = 1'b0;
    repeat (19) tick();
    check("p_hold_pen", 32'(bus.rd_ddr_param_en_o), 32'd1);
    tick();
    bus.param_done_i = 1'b1;
    tick();
    bus.param_done_i = 1'b0;
    check("p_rel_pen",  32'(bus.rd_ddr_param_en_o), 32'd0);
    check("p_gap1_busy", 32'(bus.busy_o), 32'd1);
    tick();
    check("p_gap2_busy", 32'(bus.busy_o), 32'd1);
    tick();
    check("p_idle_busy", 32'(bus.busy_o), 32'd0);

    // Contested round-robin from a fresh reset: PARAM, DATA, PARAM, DATA
    do_reset();
    bus.data_req_i  = 1'b1;
    bus.param_req_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!(bus.rd_ddr_en_o || bus.rd_ddr_param_en_o) && n < 50);
      if (g == 0) check("rr_first_lat", 32'(n), 32'd1);
      else        check("rr_dead_cyc",  32'(n), 32'd3);
      exp_data = (g % 2) == 1;
      check("rr_data_en",  32'(bus.rd_ddr_en_o),       32'(exp_data));
      check("rr_param_en", 32'(bus.rd_ddr_param_en_o), 32'(!exp_data));
      repeat (10) tick();
      if (exp_data) bus.data_done_i  = 1'b1;
      else          bus.param_done_i = 1'b1;
      tick();
      bus.data_done_i  = 1'b0;
      bus.param_done_i = 1'b0;
      check("rr_rel_en", 32'(bus.rd_ddr_en_o | bus.rd_ddr_param_en_o), 32'd0);
      if (g == 3) begin
        bus.data_req_i  = 1'b0;
        bus.param_req_i = 1'b0;
      end
    end
    repeat (3) tick();
    check("rr_idle_busy", 32'(bus.busy_o), 32'd0);

    // data_done during a param grant is ignored
    bus.param_req_i = 1'b1;
    tick();
    bus.param_req_i = 1'b0;
    check("xd_pen", 32'(bus.rd_ddr_param_en_o), 32'd1);
    repeat (2) tick();
    bus.data_done_i = 1'b1;
    tick();
    bus.data_done_i = 1'b0;
    check("xd_pen_held", 32'(bus.rd_ddr_param_en_o), 32'd1);
    check("xd_en_low",   32'(bus.rd_ddr_en_o),       32'd0);
    repeat (3) tick();
    check("xd_pen_held2", 32'(bus.rd_ddr_param_en_o), 32'd1);
    bus.param_done_i = 1'b1;
    tick();
    bus.param_done_i = 1'b0;
    check("xd_pen_rel", 32'(bus.rd_ddr_param_en_o), 32'd0);
    repeat (2) tick();
    check("xd_idle_busy", 32'(bus.busy_o), 32'd0);

    // Watchdog at 8 cycles, sticky flag, then clear
    bus.timeout_cyc_i = 16'd8;
    bus.data_req_i    = 1'b1;
    tick();
    bus.data_req_i = 1'b0;
    check("wd_en", 32'(bus.rd_ddr_en_o), 32'd1);
    repeat (7) tick();
    check("wd_en_g7",  32'(bus.rd_ddr_en_o), 32'd1);
    check("wd_to_g7",  32'(bus.timeout_o),   32'd0);
    tick();
    check("wd_en_g8",  32'(bus.rd_ddr_en_o), 32'd0);
    check("wd_to_g8",  32'(bus.timeout_o),   32'd1);
    repeat (5) tick();
    check("wd_sticky", 32'(bus.timeout_o),   32'd1);
    check("wd_idle",   32'(bus.busy_o),      32'd0);
    bus.timeout_clr_i = 1'b1;
    tick();
    bus.timeout_clr_i = 1'b0;
    check("wd_clr",    32'(bus.timeout_o),   32'd0);

    // Done and expiry in the same cycle: done wins, flag stays low
    bus.data_req_i = 1'b1;
    tick();
    bus.data_req_i = 1'b0;
    check("wdd_en", 32'(bus.rd_ddr_en_o), 32'd1);
    repeat (7) tick();
    bus.data_done_i = 1'b1;
    tick();
    bus.data_done_i = 1'b0;
    check("wdd_en_rel", 32'(bus.rd_ddr_en_o), 32'd0);
    check("wdd_to",     32'(bus.timeout_o),   32'd0);
    repeat (2) tick();
    check("wdd_idle",   32'(bus.busy_o),      32'd0);

    // Watchdog disabled: grant holds for 1000 cycles
    bus.timeout_cyc_i = '0;
    bus.data_req_i    = 1'b1;
    tick();
    bus.data_req_i = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!bus.rd_ddr_en_o) held = 1'b0;
      tick();
    end
    check("wd0_held", 32'(held & bus.rd_ddr_en_o), 32'd1);
    check("wd0_to",   32'(bus.timeout_o),          32'd0);
    bus.data_done_i = 1'b1;
    tick();
    bus.data_done_i = 1'b0;
    check("wd0_rel", 32'(bus.rd_ddr_en_o), 32'd0);
    repeat (2) tick();

    // Asynchronous reset mid data grant, then contested grant goes to PARAM
    bus.data_req_i = 1'b1;
    tick();
    bus.data_req_i = 1'b0;
    check("ar_en", 32'(bus.rd_ddr_en_o), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_en_drop", 32'(bus.rd_ddr_en_o), 32'd0);
    check("ar_busy",    32'(bus.busy_o),      32'd0);
    tick();
    rstn = 1'b1;
    bus.data_req_i  = 1'b1;
    bus.param_req_i = 1'b1;
    tick();
    bus.data_req_i  = 1'b0;
    bus.param_req_i = 1'b0;
    check("ar_pen_first", 32'(bus.rd_ddr_param_en_o), 32'd1);
    check("ar_en_first",  32'(bus.rd_ddr_en_o),       32'd0);
    bus.param_done_i = 1'b1;
    tick();
    bus.param_done_i = 1'b0;
    check("ar_pen_rel", 32'(bus.rd_ddr_param_en_o), 32'd0);
    repeat (2) tick();
    check("ar_idle", 32'(bus.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_rd_sched.md
# ddr_rd_sched

Schedules the single shared DDR read port between the feature-map data reader and the parameter (kernel/bias) reader inside the read path. It raises exactly one of the two read enables at a time, so the DDR address, command and enable muxing downstream is never ambiguous. Each grant is held until the owner signals completion. Arbitration between the two readers is round-robin, a minimum idle gap separates grants, and a programmable watchdog frees a hung grant.

## Interface
Parameters:
- GAP_CYC, default 2, number of dead cycles (both enables low) between consecutive grants; legal range 1..15.
- TO_W, default 16, width of the watchdog counter and of `timeout_cyc_i`.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  level request from the data reader; held until granted.
- data_done_i  in  1  one-cycle pulse: the data fetch is complete (last beat returned).
- param_req_i  in  1  level request from the parameter reader.
- param_done_i  in  1  one-cycle pulse: the parameter fetch is complete.
- timeout_cyc_i  in  TO_W  watchdog limit in cycles; 0 disables the watchdog.
- timeout_clr_i  in  1  clears the sticky `timeout_o` flag.
- rd_ddr_en_o  out  1  registered enable to the data reader.
- rd_ddr_param_en_o  out  1  registered enable to the parameter reader.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  sticky flag: a grant was force-released by the watchdog.

## Operation
- States: IDLE, GNT_DATA, GNT_PARAM, GAP.
- IDLE with no request: stay in IDLE.
- IDLE with only one request: go to that request's GNT state.
- IDLE with both requests: round-robin on the `last` register. Param wins if `last` = DATA; data wins if `last` = PARAM. `last` is updated on every grant.
- `last` resets to DATA, so the first contested grant goes to params.
- GNT_DATA: `rd_ddr_en_o` = 1. Go to GAP on `data_done_i`. `param_done_i` is ignored here.
- GNT_PARAM: `rd_ddr_param_en_o` = 1. Go to GAP on `param_done_i`. `data_done_i` is ignored here.
- Dropping the request while granted has no effect; the grant is held until done or watchdog.
- Watchdog:
  - `to_cnt` clears on entry to a GNT state and increments each cycle in that state.
  - If `timeout_cyc_i` != 0 and `to_cnt` == `timeout_cyc_i` - 1 with no done pulse, set `timeout_o` and go to GAP.
  - If done and watchdog expiry hit in the same cycle, done wins and `timeout_o` is not set.
  - `to_cnt` saturates at all-ones; it never wraps.
- GAP: both enables low. `gap_cnt` counts GAP_CYC cycles, then the block returns to IDLE.
- `timeout_o` clears on `timeout_clr_i`. If a set and a clear land in the same cycle, the set wins.
- The two enables are never high together; verification asserts this every cycle.

## Timing
- Reset values:
  - State IDLE, `last` = DATA, `to_cnt` = 0, `gap_cnt` = 0.
  - All outputs 0: `rd_ddr_en_o`, `rd_ddr_param_en_o`, `busy_o`, `timeout_o`.
- Reset asserted mid-grant drops the enable asynchronously; the block restarts in IDLE.
- All outputs are registered; no combinational path from input to output.
- Request latency: request high in IDLE at cycle t, enable high at t+1.
- Release latency: done at cycle t, enable low at t+1, GAP occupies t+1..t+GAP_CYC, IDLE at t+GAP_CYC+1.
- With a request pending, the next enable rises at t+GAP_CYC+2. For GAP_CYC = 2, that is 3 dead cycles between grants.
- Watchdog: grant entered with enable high at cycle g and no done pulse → enable low at g+`timeout_cyc_i`, `timeout_o` high in the same cycle.
- A done pulse in the same cycle the enable rises is honoured, giving a 1-cycle grant.
- `busy_o` rises with the enable and falls on the IDLE entry cycle.

## Test plan
- Reset, then `param_req_i` = 1 only → `rd_ddr_param_en_o` = 1 one cycle later. `param_done_i` pulsed 20 cycles later → enable low next cycle, `busy_o` low 3 cycles after the done pulse.
- Both requests held from cycle 0 (first contested grant), each done pulsed 10 cycles after its own grant → grant order PARAM, DATA, PARAM, DATA. Exactly 3 dead cycles between grants. The two enables are never high together.
- `data_done_i` pulsed during GNT_PARAM → ignored; the param grant continues until `param_done_i`.
- `timeout_cyc_i` = 8, data granted, no done → enable low after 8 cycles, `timeout_o` = 1 and sticky. `timeout_clr_i` → `timeout_o` = 0. With `timeout_cyc_i` = 0 the grant holds for 1000 cycles without release.
- `rstn_i` pulsed low mid-GNT_DATA → `rd_ddr_en_o` drops immediately. After release, a contested request is granted to PARAM first (`last` reset to DATA).
- `data_done_i` and watchdog expiry in the same cycle → release to GAP, `timeout_o` stays 0.
